// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, arbitration defaults and memory-owner encoding
package cpu_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int MAX_D_STREAK_DEF = 4;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;
endpackage

// File: rtl/arb_streak_ctr.sv
// arb_streak_ctr: counts data grants taken while a fetch waits and raises force_if at the limit
module arb_streak_ctr import cpu_pkg::*; #(
  parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic if_xfer,
  input  logic d_xfer,
  output logic force_if
);
  logic [3:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (if_xfer || !if_req) cnt <= '0;
    else if (d_xfer && cnt != 4'(MAX_D_STREAK)) cnt <= cnt + 4'd1;
  assign force_if = if_req && cnt == 4'(MAX_D_STREAK);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port memory between fetch and load/store,
// routing the 1-cycle read response back to whichever side issued it
module mem_arbiter import cpu_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  owner_e owner, owner_nxt;
  logic force_if;
  logic [DATA_W-1:0] if_hold, d_hold;

  arb_streak_ctr #(.MAX_D_STREAK(MAX_D_STREAK)) u_streak (
    .clk(clk), .rst_n(rst_n), .if_req(if_req),
    .if_xfer(if_gnt), .d_xfer(d_gnt), .force_if(force_if)
  );

  always_comb begin
    if_gnt = rst_n && if_req && (!d_req || force_if);
    d_gnt = rst_n && d_req && !if_gnt;
    mem_we = d_gnt && d_we;
    mem_addr = d_gnt ? d_addr : if_addr;
    mem_wdata = d_gnt ? d_wdata : '0;
    owner_nxt = if_gnt ? OWN_IF : (d_gnt && !d_we) ? OWN_D : OWN_NONE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      owner <= OWN_NONE;
      if_hold <= '0;
      d_hold <= '0;
    end else begin
      owner <= owner_nxt;
      if (if_rvalid) if_hold <= mem_rdata;
      if (d_rvalid) d_hold <= mem_rdata;
    end

  // the non-owner side keeps presenting the last word it received
  assign if_rvalid = owner == OWN_IF;
  assign d_rvalid = owner == OWN_D;
  assign if_rdata = if_rvalid ? mem_rdata : if_hold;
  assign d_rdata = d_rvalid ? mem_rdata : d_hold;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, reset corner case and random traffic checked
// against a transaction-level model of the arbiter with a shadow memory
module tb_mem_arbiter;
  localparam int MAXS = 4;
  logic clk = 0, rst_n = 0;
  logic if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:2]];
  end

  int n_cmp = 0, n_bad = 0;
  int streak, pend;
  logic [31:0] pdata, last_if, last_d;
  logic [31:0] sh [256];

  typedef struct {
    logic ir, dr, we;
    logic [31:0] ia, da, wd;
    logic eig, edg;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic ir, logic dr, logic we, logic [31:0] ia, logic [31:0] da,
                              logic [31:0] wd, logic eig, logic edg);
    vec_t v;
    v.ir = ir; v.dr = dr; v.we = we; v.ia = ia; v.da = da; v.wd = wd; v.eig = eig; v.edg = edg;
    return v;
  endfunction

  task automatic model_reset();
    streak = 0; pend = 0; pdata = 0; last_if = 0; last_d = 0;
  endtask

  task automatic cyc(input logic ir, input logic dr, input logic we, input logic [31:0] ia,
                     input logic [31:0] da, input logic [31:0] wd, output logic gi, output logic gd);
    logic eig, edg;
    @(negedge clk);
    if_req = ir; d_req = dr; d_we = we; if_addr = ia; d_addr = da; d_wdata = wd;
    #1;
    eig = ir && (!dr || streak == MAXS);
    edg = dr && !eig;
    gi = if_gnt; gd = d_gnt;
    chk("if_gnt", if_gnt, eig);
    chk("d_gnt", d_gnt, edg);
    chk("mem_we", mem_we, edg && we);
    if (eig || edg) chk("mem_addr", mem_addr, edg ? da : ia);
    if (edg && we) chk("mem_wdata", mem_wdata, wd);
    if (!eig && !edg) chk("mem_wdata_idle", mem_wdata, 0);
    chk("if_rvalid", if_rvalid, pend == 1);
    chk("d_rvalid", d_rvalid, pend == 2);
    if (pend == 1) last_if = pdata;
    if (pend == 2) last_d = pdata;
    chk("if_rdata", if_rdata, last_if);
    chk("d_rdata", d_rdata, last_d);
    @(posedge clk);
    streak = (eig || !ir) ? 0 : (edg && streak < MAXS) ? streak + 1 : streak;
    pend = eig ? 1 : (edg && !we) ? 2 : 0;
    pdata = eig ? sh[ia[9:2]] : sh[da[9:2]];
    if (edg && we) sh[da[9:2]] = wd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; if_req = 1; d_req = 1; d_we = 0;
    #1;
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_we", mem_we, 0);
    repeat (2) @(negedge clk);
    rst_n = 1; if_req = 0; d_req = 0;
    model_reset();
  endtask

  initial begin
    logic gi, gd;
    logic [1:0] exp5 [5];
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0203);
      sh[i] = mem[i];
    end
    model_reset();
    do_reset();
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 32'h0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 32'h40, 32'hDEADBEEF, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 32'h40, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h80, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h84, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1, 1, 0, 32'h100 + 4 * i, 32'h200 + 4 * i, 0, i % 5 == 4, i % 5 != 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 32'h300, 32'h10, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 32'h300, 32'h14, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 32'h300, 32'h18, 0, 0, 1));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 1, 0, 32'h300, 32'h20 + 4 * i, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 32'h300, 32'h30, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (tbl[k]) begin
      cyc(tbl[k].ir, tbl[k].dr, tbl[k].we, tbl[k].ia, tbl[k].da, tbl[k].wd, gi, gd);
      chk($sformatf("tbl%0d_if_gnt", k), gi, tbl[k].eig);
      chk($sformatf("tbl%0d_d_gnt", k), gd, tbl[k].edg);
    end
    // build a streak of 4 ending on a load, then reset while its response is due
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 32'h8, 32'hC0 + 4 * i, 0, gi, gd);
    do_reset();
    exp5 = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 0, 32'h8, 32'hE0 + 4 * i, 0, gi, gd);
      chk($sformatf("post_rst%0d_grant", i), {gi, gd}, exp5[i]);
    end
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          $urandom, $urandom, $urandom, gi, gd);
    cyc(0, 0, 0, 0, 0, 0, gi, gd);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
